// File: rtl/ser_tx_shift.sv
// ser_tx_shift: parallel-in / serial-out byte transmitter.
//
// Accepts a byte on a load/ready handshake, keeps one further byte in a hold
// register, and shifts each byte out MSB first with a companion shift clock.
// The receiver samples sout on the rising edge of sclk and left-shifts, which
// reassembles the original byte. Bytes queued in the hold register follow the
// current byte with no gap.
//
// Optional feature: define SER_TX_PARITY_EN to append an odd-parity bit
// (~^byte) after the LSB of every byte, one extra bit period with one sclk
// pulse. Without the macro each byte takes DATA_W*CLK_DIV cycles.
//
// Parameters:
//   DATA_W   bits per byte (2..15)
//   CLK_DIV  clk cycles per serial bit (even, >= 2)
// Ports:
//   clk    system clock, rising-edge active
//   reset  asynchronous active-high reset; aborts any transfer, empties hold
//   din    byte to send, sampled only when a load is accepted
//   load   load strobe, accepted when load & ready on a clk edge
//   ready  hold register empty, a new byte can be accepted
//   busy   a byte is being shifted out
//   sout   serial data, MSB first (registered)
//   sclk   shift clock, high in the second half of each bit period (registered)
//   done   one-cycle pulse after the last bit period of each byte (registered)
module ser_tx_shift #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              load,
   output logic              ready,
   output logic              busy,
   output logic              sout,
   output logic              sclk,
   output logic              done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
   localparam logic [3:0]       BCNT_LAST = 4'(DATA_W - 1);

`ifdef SER_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t            state, nxt_state;
   logic [DIV_W-1:0]  div, nxt_div;
   logic [3:0]        bcnt, nxt_bcnt;
   logic              hfull, nxt_hfull;
   logic              xfer, nxt_xfer;
   logic              nxt_sout, nxt_sclk, nxt_done;
   logic [DATA_W-1:0] sh, nxt_sh;
   logic [DATA_W-1:0] hold, nxt_hold;
   logic              accept, end_byte;
`ifdef SER_TX_PARITY_EN
   logic              par, nxt_par;

   function automatic logic odd_par(input logic [DATA_W-1:0] b);
      return ~^b;
   endfunction
`endif

   // xfer marks the cycle right after a hold->shift transfer; the hold
   // register is already empty then, but the handshake stays closed one cycle.
   assign ready  = ~hfull & ~xfer;
   assign busy   = (state != IDLE);
   assign accept = load & ready;

   always_comb begin
      nxt_state = state;
      nxt_div   = div;
      nxt_bcnt  = bcnt;
      nxt_sh    = sh;
      nxt_hold  = hold;
      nxt_hfull = hfull;
      nxt_xfer  = 1'b0;
      nxt_done  = 1'b0;
      nxt_sout  = 1'b0;
      nxt_sclk  = 1'b0;
      end_byte  = 1'b0;
`ifdef SER_TX_PARITY_EN
      nxt_par   = par;
`endif

      case (state)
         IDLE: begin
            if (accept) begin
               nxt_state = SHIFT;
               nxt_sh    = din;
               nxt_div   = '0;
               nxt_bcnt  = '0;
`ifdef SER_TX_PARITY_EN
               nxt_par   = odd_par(din);
`endif
            end
         end
         SHIFT: begin
            nxt_div = div + 1'b1;
            if (div == DIV_LAST) begin
               nxt_div  = '0;
               nxt_sh   = {sh[DATA_W-2:0], 1'b0};
               nxt_bcnt = bcnt + 4'd1;
               if (bcnt == BCNT_LAST) begin
`ifdef SER_TX_PARITY_EN
                  nxt_state = PAR;
`else
                  end_byte  = 1'b1;
`endif
               end
            end
         end
`ifdef SER_TX_PARITY_EN
         PAR: begin
            nxt_div = div + 1'b1;
            if (div == DIV_LAST) begin
               nxt_div  = '0;
               end_byte = 1'b1;
            end
         end
`endif
         default: nxt_state = IDLE;
      endcase

      // A load while shifting lands in the hold register.
      if ((state != IDLE) && accept) begin
         nxt_hold  = din;
         nxt_hfull = 1'b1;
      end

      // End of byte: chain the held byte (or a byte loaded this very cycle
      // while hold is empty) without a gap, otherwise return to idle.
      if (end_byte) begin
         nxt_done = 1'b1;
         nxt_div  = '0;
         nxt_bcnt = '0;
         if (hfull) begin
            nxt_state = SHIFT;
            nxt_sh    = hold;
            nxt_hfull = 1'b0;
            nxt_xfer  = 1'b1;
`ifdef SER_TX_PARITY_EN
            nxt_par   = odd_par(hold);
`endif
         end else if (accept) begin
            nxt_state = SHIFT;
            nxt_sh    = din;
            nxt_hfull = 1'b0;
`ifdef SER_TX_PARITY_EN
            nxt_par   = odd_par(din);
`endif
         end else begin
            nxt_state = IDLE;
         end
      end

      // Outputs are registered, so they are derived from the next state.
      case (nxt_state)
         SHIFT:   nxt_sout = nxt_sh[DATA_W-1];
`ifdef SER_TX_PARITY_EN
         PAR:     nxt_sout = nxt_par;
`endif
         default: nxt_sout = 1'b0;
      endcase
      nxt_sclk = (nxt_state != IDLE) && (nxt_div >= DIV_HALF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         div   <= '0;
         bcnt  <= '0;
         hfull <= 1'b0;
         xfer  <= 1'b0;
         sout  <= 1'b0;
         sclk  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nxt_state;
         div   <= nxt_div;
         bcnt  <= nxt_bcnt;
         hfull <= nxt_hfull;
         xfer  <= nxt_xfer;
         sout  <= nxt_sout;
         sclk  <= nxt_sclk;
         done  <= nxt_done;
      end
   end

   // Byte storage carries no reset; hfull and state qualify its contents.
   always_ff @(posedge clk) begin
      sh   <= nxt_sh;
      hold <= nxt_hold;
`ifdef SER_TX_PARITY_EN
      par  <= nxt_par;
`endif
   end

endmodule

// File: tb/tb_ser_tx_shift.sv
// Testbench for ser_tx_shift: directed steps with a serial receiver model and
// a scoreboard of expected bits and bytes.
`timescale 1ns/1ps
module tb_ser_tx_shift;

   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 4;
`ifdef SER_TX_PARITY_EN
   localparam int FRAME = DATA_W + 1;
`else
   localparam int FRAME = DATA_W;
`endif
   localparam int BYTE_CYC = FRAME * CLK_DIV;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] din;
   logic              load;
   logic              ready, busy, sout, sclk, done;

   int n_cmp = 0;
   int n_bad = 0;

   logic              bit_q[$];
   logic [DATA_W-1:0] byte_q[$];
   int                done_cnt = 0;
   logic              prev_sclk = 1'b0;
   logic [DATA_W-1:0] rx_byte = '0;
   int                rx_cnt = 0;

   always #5 clk = ~clk;

   ser_tx_shift #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .load  (load),
      .ready (ready),
      .busy  (busy),
      .sout  (sout),
      .sclk  (sclk),
      .done  (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [DATA_W-1:0] b, input int k);
      if (k < DATA_W) return b[DATA_W-1-k];
      return ~^b;
   endfunction

   task automatic push_frame(input logic [DATA_W-1:0] b);
      for (int k = 0; k < FRAME; k++) bit_q.push_back(exp_bit(b, k));
      byte_q.push_back(b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: samples sout on each sclk rise, checks it against the
   // scoreboard, left-shifts it into rx_byte, and checks the byte on done.
   always @(negedge clk) begin
      if (reset) begin
         rx_cnt = 0;
      end else begin
         if (sclk && !prev_sclk) begin
            check("sclk_rise_expected", 32'(bit_q.size() != 0), 32'd1);
            if (bit_q.size() != 0) begin
               check("sout_bit", 32'(sout), 32'(bit_q.pop_front()));
               if (rx_cnt < DATA_W) rx_byte = {rx_byte[DATA_W-2:0], sout};
               rx_cnt++;
            end
         end
         if (done) begin
            done_cnt++;
            check("done_expected", 32'(byte_q.size() != 0), 32'd1);
            if (byte_q.size() != 0) begin
               check("rx_byte", 32'(rx_byte), 32'(byte_q.pop_front()));
               check("rx_bits", 32'(rx_cnt), 32'(FRAME));
            end
            rx_cnt = 0;
         end
      end
      prev_sclk = sclk;
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      check({tag, "_busy"},  32'(busy),  32'd0);
      check({tag, "_sout"},  32'(sout),  32'd0);
      check({tag, "_sclk"},  32'(sclk),  32'd0);
      check({tag, "_done"},  32'(done),  32'd0);
   endtask

   // Load one byte from idle and check every cycle of its frame.
   task automatic run_single(input logic [DATA_W-1:0] b);
      din  = b;
      load = 1'b1;
      push_frame(b);
      tick();
      load = 1'b0;
      for (int c = 1; c <= BYTE_CYC + 1; c++) begin
         check("single_busy",  32'(busy),  32'(c <= BYTE_CYC));
         check("single_done",  32'(done),  32'(c == BYTE_CYC + 1));
         check("single_ready", 32'(ready), 32'd1);
         if (c <= BYTE_CYC) begin
            check("single_sclk", 32'(sclk), 32'(((c - 1) % CLK_DIV) >= CLK_DIV / 2));
            check("single_sout", 32'(sout), 32'(exp_bit(b, (c - 1) / CLK_DIV)));
         end else begin
            check("single_sclk_end", 32'(sclk), 32'd0);
            check("single_sout_end", 32'(sout), 32'd0);
         end
         din = DATA_W'($urandom);
         tick();
      end
   endtask

   initial begin
      int d0;
      reset = 1'b1;
      load  = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      tick();

      // Single byte, din scrambled while busy.
      run_single(8'hA5);
      tick();

      // Back-to-back 0x3C then 0xC3 held; 0xFF while hold is full is ignored.
      din  = 8'h3C;
      load = 1'b1;
      push_frame(8'h3C);
      tick();
      load = 1'b0;
      for (int c = 1; c <= 2 * BYTE_CYC + 2; c++) begin
         check("b2b_ready", 32'(ready), 32'((c <= 5) || (c >= BYTE_CYC + 2)));
         check("b2b_done",  32'(done),  32'((c == BYTE_CYC + 1) || (c == 2 * BYTE_CYC + 1)));
         check("b2b_busy",  32'(busy),  32'(c <= 2 * BYTE_CYC));
         if (c == BYTE_CYC + 1) check("b2b_next_msb", 32'(sout), 32'd1);
         load = 1'b0;
         if (c == 5) begin
            din  = 8'hC3;
            load = 1'b1;
            push_frame(8'hC3);
         end else if (c == 10) begin
            din  = 8'hFF;
            load = 1'b1;
         end else begin
            din = DATA_W'($urandom);
         end
         tick();
      end
      load = 1'b0;
      tick();

      // Parity-relevant byte (parity bit is 0 when the macro is enabled).
      run_single(8'h01);
      tick();

      // Reset in the middle of 0xA5 with 0x5A held.
      din  = 8'hA5;
      load = 1'b1;
      push_frame(8'hA5);
      tick();
      load = 1'b0;
      for (int c = 1; c < 15; c++) begin
         load = 1'b0;
         if (c == 3) begin
            din  = 8'h5A;
            load = 1'b1;
         end
         tick();
      end
      load = 1'b0;
      check("pre_reset_sclk", 32'(sclk), 32'd1);
      check("pre_reset_ready", 32'(ready), 32'd0);
      d0 = done_cnt;
      bit_q.delete();
      byte_q.delete();
      reset = 1'b1;
      din   = 8'h77;
      load  = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      tick();
      load  = 1'b0;
      reset = 1'b0;
      repeat (BYTE_CYC + 4) begin
         check("after_reset_busy", 32'(busy), 32'd0);
         check("after_reset_sout", 32'(sout), 32'd0);
         tick();
      end
      check("after_reset_ready", 32'(ready), 32'd1);
      check("after_reset_no_done", 32'(done_cnt), 32'(d0));

      run_single(8'h81);
      repeat (4) tick();

      check("bit_queue_drained", 32'(bit_q.size()), 32'd0);
      check("byte_queue_drained", 32'(byte_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ser_tx_shift.md
# ser_tx_shift

Parallel-in/serial-out transmitter that pairs with the USB-side serial-in shift register: it accepts bytes over a ready/load handshake, double-buffers one byte, and shifts each byte out MSB first with a companion shift clock, so the receiver's left-shift reassembles the original byte. It sits between the CPU/USB control logic and the serial link, and reports byte completion to the control logic.

## Interface
- DATA_W, 8: bits per byte; supported range 2..15.
- CLK_DIV, 4: clk cycles per serial bit; even, ≥2.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  byte to send; sampled only when the load is accepted.
- load  input  1  load strobe; accepted when load=1 and ready=1 on a clk edge.
- ready  output  1  hold register empty; a new byte can be accepted.
- busy  output  1  a byte is being shifted out.
- sout  output  1  serial data, MSB first.
- sclk  output  1  shift clock; the receiver samples sout on its rising edge.
- done  output  1  one-cycle pulse after the last bit period of each byte.

## Operation
- Storage: shift register `sh`, hold register `hold` with flag `hfull`, divider counter `div` (0..CLK_DIV-1), and bit counter `bcnt` (4 bits).
- States: IDLE, SHIFT, PAR (PAR exists only with the configuration macro enabled).
- IDLE:
  - A load is accepted into `sh` directly and the state moves to SHIFT. `hold` stays empty, so ready stays 1.
  - sout=0, sclk=0, busy=0.
- SHIFT:
  - sout=`sh[DATA_W-1]`.
  - `div` increments each cycle.
  - When `div`=CLK_DIV-1: `div`→0, `sh` shifts left (zero fill), and `bcnt` increments.
  - When `bcnt` reaches DATA_W-1 at the last wrap, the byte is finished.
- A load accepted while busy goes to `hold`; `hfull`=1 and ready=0.
- End of byte:
  - If `hfull`=1: `hold`→`sh`, `hfull`→0, stay in SHIFT, counters cleared. There is no gap between bytes.
  - If `hfull`=0: go to IDLE.
  - In both cases done=1 for exactly one cycle.
- sclk=1 while `div` ≥ CLK_DIV/2 in SHIFT/PAR, and 0 otherwise.
- Boundary conditions:
  - A load while ready=0 is ignored; `hold` is never overwritten.
  - In the cycle `hold` transfers to `sh`, ready is still 0, so a load that cycle is ignored. ready=1 from the next cycle.
  - Changes on din while busy have no effect on the byte in flight.
- Reset (asserted at any time, including mid-byte): aborts the transfer and clears `hold`. Outputs return to reset values immediately, asynchronously.

## Timing
- Reset values: ready=1, busy=0, sout=0, sclk=0, done=0. Internally: state IDLE, `hfull`=0, counters 0.
- Load accepted at edge E0 from IDLE:
  - busy=1 and sout=din[DATA_W-1] from cycle 1.
  - Bit k (0 = MSB) is driven during cycles 1+k·CLK_DIV .. (k+1)·CLK_DIV.
  - sclk rises at cycle 1+k·CLK_DIV+CLK_DIV/2.
- Completion: done=1 in cycle DATA_W·CLK_DIV+1; with an empty hold, busy=0 in the same cycle.
- Back-to-back: the held byte's MSB appears in cycle DATA_W·CLK_DIV+1, while done=1.
- Latency from load to first sclk rise is 1+CLK_DIV/2 cycles.
- All outputs are registered except ready and busy, which decode registered state.

## Configuration
- SER_TX_PARITY_EN defined:
  - After the LSB, the block enters PAR and drives the odd-parity bit (~^byte) for CLK_DIV cycles, with one sclk pulse.
  - The byte takes (DATA_W+1)·CLK_DIV cycles; done follows the parity bit.
  - Hold transfer happens at the end of PAR.
- SER_TX_PARITY_EN undefined: PAR does not exist and bytes are DATA_W·CLK_DIV cycles.

## Test plan
- Reset mid-operation → ready=1, busy=0, sout=0, sclk=0, done=0 immediately. A load in the same cycle as reset is lost.
- DATA_W=8, CLK_DIV=4, load 0xA5 from IDLE:
  - sout 1,0,1,0,0,1,0,1, each 4 cycles.
  - sclk rises at cycles 3,7,…,31.
  - done=1 and busy=0 at cycle 33.
- Load 0x3C then, at cycle 5, load 0xC3:
  - ready=0 from cycle 6 to 33.
  - At cycle 33, done=1 and sout=1 (0xC3 MSB).
  - A second done at cycle 65.
- With hold full, pulse load with 0xFF at cycle 10 → ignored; only 0x3C and 0xC3 are transmitted.
- Parity build, load 0x01:
  - Parity bit 0 on sout for cycles 33–36.
  - done at cycle 37.
  - A bench feeding sclk/sout to the serial-in receiver reads 0x01.
- Assert reset at cycle 15 of 0xA5 with 0x5A held → no done; after release, sout=0 and ready=1, and the next load of 0x81 transmits cleanly.
